fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the program counter and drives the word address into the
//  combinational instruction memory. Captures the returned word into the IF/ID pipeline register
//  for decode. Handles stall, branch/jump redirect (flush) and fault/EBREAK halt.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte address fetched first after reset (word aligned)
//  IMEM_DEPTH  10             number of 32-bit words in instruction memory; valid word index 0..IMEM_DEPTH-1
//  NOP_INST    32'h0000_0013  bubble word (addi x0,x0,0) placed in IF/ID when not valid
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous active-high reset
//  stall_i        in   1   hold PC and IF/ID (hazard from decode)
//  redirect_i     in   1   taken branch/jump resolved in EX; flush IF/ID
//  redirect_pc_i  in   32  byte target address for redirect
//  imem_addr      out  32  word index to instruction memory = {2'b00, pc[31:2]}, combinational from pc
//  imem_inst      in   32  instruction word returned same cycle
//  ifid_pc        out  32  byte PC of instruction held in IF/ID
//  ifid_inst      out  32  instruction held in IF/ID
//  ifid_valid     out  1   IF/ID holds a real instruction
//  fetch_fault    out  1   sticky: out-of-range PC or misaligned redirect
//  halted         out  1   high while in HALT
// BEHAVIOUR
//  Reset (rst=1 at edge): state=BOOT, pc=RESET_PC, ifid_pc=0, ifid_inst=NOP_INST, ifid_valid=0,
//   fetch_fault=0; halted=0. Reset wins over every other input, including mid-stall/mid-redirect.
//  States: BOOT -> RUN -> HALT.
//  BOOT: one cycle, nothing captured (ifid_valid stays 0), pc unchanged; unconditionally -> RUN.
//   This gives the memory its post-reset settle cycle.
//  RUN, priority per edge (highest first):
//   1 redirect_i, redirect_pc_i[1:0]!=0: fetch_fault<=1, ifid_valid<=0, ifid_inst<=NOP, -> HALT.
//   2 redirect_i aligned: pc<=redirect_pc_i, ifid_valid<=0, ifid_inst<=NOP. Overrides stall_i.
//   3 stall_i: pc, ifid_* all hold.
//   4 pc[31:2] >= IMEM_DEPTH: fetch_fault<=1, ifid_valid<=0, ifid_inst<=NOP, pc holds, -> HALT.
//   5 normal: ifid_pc<=pc, ifid_inst<=imem_inst, ifid_valid<=1, pc<=pc+4 (mod 2^32).
//     If imem_inst==32'h0010_0073 (EBREAK): captured as in 5 but pc holds, -> HALT.
//  Latency: instruction at pc appears in IF/ID one edge after pc is presented (fetch to decode = 1 cycle).
//  HALT: halted=1. On the first HALT edge, IF/ID is overwritten with a bubble (ifid_valid<=0,
//   ifid_inst<=NOP); the captured EBREAK is therefore visible for exactly one cycle. pc then holds.
//   Aligned redirect_i while fetch_fault=0 (speculative EBREAK): pc<=redirect_pc_i, -> RUN,
//   halted drops next cycle.
//   With fetch_fault=1, HALT is left only by rst; redirect and stall are ignored.
//  stall_i in BOOT/HALT is ignored. pc never advances beyond the out-of-range check. No wrap fetch.
// TESTING
//  1 rst 2 cycles, IMEM words W0..W3; release -> BOOT cycle ifid_valid=0, then
//    ifid_pc=0,4,8 / ifid_inst=W0,W1,W2 / valid=1 on consecutive cycles.
//  2 stall_i=1 for 3 cycles once pc=8 -> imem_addr stays 2, ifid_pc=4 held, valid=1; release -> ifid_pc=8.
//  3 redirect_i=1, redirect_pc_i=0x20, stall_i=1 same cycle -> next: ifid_valid=0, imem_addr=8;
//    following: ifid_pc=0x20, valid=1.
//  4 IMEM_DEPTH=10 straight run -> ifid_pc=0x24 captured, then fetch_fault=1, halted=1,
//    ifid_valid=0, pc=0x28 held; redirect ignored.
//  5 W3=0x00100073 -> ifid_inst=0x00100073 valid 1 cycle, halted=1;
//    redirect to 0x04 -> RUN, ifid_pc=0x04 next.
//  6 redirect_pc_i=0x22 -> fetch_fault=1, halted=1; rst mid-run -> pc=RESET_PC, fault cleared, BOOT.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and fills the
// IF/ID register, with stall, redirect/flush and fault/EBREAK halt handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 10,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic        halted
);

    localparam logic [1:0]  S_BOOT  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_HALT  = 2'd2;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifidPc_q, ifidPc_d;
    logic [31:0] ifidInst_q, ifidInst_d;
    logic        ifidValid_q, ifidValid_d;
    logic        fault_q, fault_d;

    logic        redirectAligned;
    logic        redirectMisaligned;
    logic        outOfRange;

    assign redirectAligned    = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign redirectMisaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign outOfRange         = (pc_q[31:2] >= DEPTH_W);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifidPc_d    = ifidPc_q;
        ifidInst_d  = ifidInst_q;
        ifidValid_d = ifidValid_q;
        fault_d     = fault_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (redirectMisaligned) begin
                    fault_d     = 1'b1;
                    ifidValid_d = 1'b0;
                    ifidInst_d  = NOP_INST;
                    state_d     = S_HALT;
                end else if (redirectAligned) begin
                    pc_d        = redirect_pc_i;
                    ifidValid_d = 1'b0;
                    ifidInst_d  = NOP_INST;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (outOfRange) begin
                    fault_d     = 1'b1;
                    ifidValid_d = 1'b0;
                    ifidInst_d  = NOP_INST;
                    state_d     = S_HALT;
                end else begin
                    ifidPc_d    = pc_q;
                    ifidInst_d  = imem_inst;
                    ifidValid_d = 1'b1;
                    // EBREAK is still handed to decode, but fetching stops on it
                    if (imem_inst == EBREAK) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            S_HALT: begin
                // Rewriting the bubble every halted cycle is idempotent after the first edge
                ifidValid_d = 1'b0;
                ifidInst_d  = NOP_INST;
                if (redirectAligned && !fault_q) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            ifidPc_q    <= 32'd0;
            ifidInst_q  <= NOP_INST;
            ifidValid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifidPc_q    <= ifidPc_d;
            ifidInst_q  <= ifidInst_d;
            ifidValid_q <= ifidValid_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_addr   = {2'b00, pc_q[31:2]};
    assign ifid_pc     = ifidPc_q;
    assign ifid_inst   = ifidInst_q;
    assign ifid_valid  = ifidValid_q;
    assign fetch_fault = fault_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/reset traffic,
// all compared each cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam int          DEPTH    = 10;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          M_BOOT   = 0;
    localparam int          M_RUN    = 1;
    localparam int          M_HALT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallIn = 1'b0;
    logic        redirectIn = 1'b0;
    logic [31:0] redirectPcIn = 32'd0;
    logic [31:0] imemAddr;
    logic [31:0] imemInst;
    logic [31:0] ifidPc;
    logic [31:0] ifidInst;
    logic        ifidValid;
    logic        fetchFault;
    logic        haltedOut;

    logic [31:0] mem [16];

    int          checks = 0;
    int          errors = 0;

    int          mMode;
    logic [31:0] mPc;
    logic [31:0] mIfPc;
    logic [31:0] mIfInst;
    logic        mIfValid;
    logic        mFault;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .IMEM_DEPTH(DEPTH),
        .NOP_INST  (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stallIn),
        .redirect_i   (redirectIn),
        .redirect_pc_i(redirectPcIn),
        .imem_addr    (imemAddr),
        .imem_inst    (imemInst),
        .ifid_pc      (ifidPc),
        .ifid_inst    (ifidInst),
        .ifid_valid   (ifidValid),
        .fetch_fault  (fetchFault),
        .halted       (haltedOut)
    );

    always #5 clk = ~clk;

    assign imemInst = (imemAddr < 32'(DEPTH)) ? mem[imemAddr[3:0]] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic fillMem(input bit withBreak);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (w == EBREAK) w = w ^ 32'd1;
            if (withBreak && $urandom_range(0, 7) == 0) w = EBREAK;
            mem[i] = w;
        end
    endtask

    // Behavioural model of one clock edge, evaluated with the inputs about to be sampled
    task automatic modelEdge(input logic st, input logic rd, input logic [31:0] rpc, input logic rs);
        logic [31:0] word;
        if (rs) begin
            mMode    = M_BOOT;
            mPc      = RESET_PC;
            mIfPc    = 32'd0;
            mIfInst  = NOP;
            mIfValid = 1'b0;
            mFault   = 1'b0;
        end else if (mMode == M_BOOT) begin
            mMode = M_RUN;
        end else if (mMode == M_RUN) begin
            if (rd && (rpc % 4 != 0)) begin
                mFault = 1'b1; mIfValid = 1'b0; mIfInst = NOP; mMode = M_HALT;
            end else if (rd) begin
                mPc = rpc; mIfValid = 1'b0; mIfInst = NOP;
            end else if (st) begin
                mPc = mPc;
            end else if (mPc / 4 >= DEPTH) begin
                mFault = 1'b1; mIfValid = 1'b0; mIfInst = NOP; mMode = M_HALT;
            end else begin
                word     = mem[mPc / 4];
                mIfPc    = mPc;
                mIfInst  = word;
                mIfValid = 1'b1;
                if (word == EBREAK) mMode = M_HALT;
                else mPc = mPc + 4;
            end
        end else begin
            mIfValid = 1'b0;
            mIfInst  = NOP;
            if (rd && (rpc % 4 == 0) && !mFault) begin
                mPc   = rpc;
                mMode = M_RUN;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("imem_addr", imemAddr, mPc / 4);
        checkOutput("ifid_valid", 32'(ifidValid), 32'(mIfValid));
        checkOutput("ifid_inst", ifidInst, mIfInst);
        checkOutput("fetch_fault", 32'(fetchFault), 32'(mFault));
        checkOutput("halted", 32'(haltedOut), 32'(mMode == M_HALT));
        if (mIfValid) checkOutput("ifid_pc", ifidPc, mIfPc);
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then compares
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc, input logic rs);
        rst          = rs;
        stallIn      = st;
        redirectIn   = rd;
        redirectPcIn = rpc;
        modelEdge(st, rd, rpc, rs);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        fillMem(1'b0);
        $display("[TB] reset and straight-line fetch");
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
        checkOutput("rst_valid", 32'(ifidValid), 32'd0);
        checkOutput("rst_inst", ifidInst, NOP);
        checkOutput("rst_addr", imemAddr, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("boot_valid", 32'(ifidValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("w0_pc", ifidPc, 32'd0);
        checkOutput("w0_inst", ifidInst, mem[0]);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("w1_pc", ifidPc, 32'd4);

        $display("[TB] stall with pc at 8");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("stall_addr", imemAddr, 32'd2);
            checkOutput("stall_pc", ifidPc, 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("unstall_pc", ifidPc, 32'd8);

        $display("[TB] redirect overriding stall");
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
        checkOutput("redir_valid", 32'(ifidValid), 32'd0);
        checkOutput("redir_addr", imemAddr, 32'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("redir_pc", ifidPc, 32'h20);

        $display("[TB] run off the end of memory");
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("last_pc", ifidPc, 32'h24);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("oor_fault", 32'(fetchFault), 32'd1);
        checkOutput("oor_addr", imemAddr, 32'd10);
        applyStimulus(1'b0, 1'b1, 32'h4, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h8, 1'b0);
        checkOutput("oor_stuck", 32'(haltedOut), 32'd1);

        $display("[TB] EBREAK halt and speculative recovery");
        mem[3] = EBREAK;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("brk_inst", ifidInst, EBREAK);
        checkOutput("brk_halted", 32'(haltedOut), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("brk_bubble", 32'(ifidValid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h4, 1'b0);
        checkOutput("brk_resume", 32'(haltedOut), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("brk_next_pc", ifidPc, 32'h4);

        $display("[TB] misaligned redirect and reset mid-run");
        applyStimulus(1'b0, 1'b1, 32'h22, 1'b0);
        checkOutput("mis_fault", 32'(fetchFault), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b1);
        checkOutput("rst_clear", 32'(fetchFault), 32'd0);
        checkOutput("rst_pc", imemAddr, RESET_PC / 4);

        $display("[TB] random traffic");
        fillMem(1'b1);
        for (int i = 0; i < 600; i++) begin
            logic st, rd, rs;
            logic [31:0] rpc;
            rs  = ($urandom_range(0, 99) < 4);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = 32'($urandom_range(0, 13)) * 4;
            if ($urandom_range(0, 4) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            if (rs) fillMem(1'b1);
            applyStimulus(st, rd, rpc, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
